// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : FSM states of the memory handshake sequencer
//   F3_*        : funct3 encodings of the RV32 load/store access sizes
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
// Request side (live core inputs):
//   i_is_store    : 1 = store, 0 = load
//   i_req_funct3  : access size/sign
//   i_req_addr_lo : daddr[1:0]
//   i_wdata       : store data (rs2)
//   o_be          : byte enables
//   o_wdata       : store data replicated across the addressed lanes
//   o_legal       : funct3 is a valid encoding for this access direction
//   o_misaligned  : address not naturally aligned for the access size
// Load side (registered copies from the accepted request):
//   i_ld_funct3, i_ld_addr_lo, i_rdata : captured request and read word
//   o_rdata_ext   : selected lane, sign/zero extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [1:0]  i_req_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_legal,
  output logic        o_misaligned,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request side: legality, alignment, enables and replicated data.
  always_comb begin
    o_legal      = 1'b0;
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;

    case (i_req_funct3)
      F3_B, F3_H, F3_W: o_legal = 1'b1;
      F3_BU, F3_HU:     o_legal = !i_is_store;  // unsigned forms exist only for loads
      default:          o_legal = 1'b0;
    endcase

    // funct3[1:0] encodes the size for every legal encoding.
    case (i_req_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_req_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_misaligned = i_req_addr_lo[0];
        o_be         = 4'b0011 << {i_req_addr_lo[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
      end
      default: begin
        o_misaligned = (i_req_addr_lo != 2'b00);
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
      end
    endcase
  end

  // Load side: lane select then extension.
  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_ld_funct3)
      F3_B:    o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata_ext = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata_ext = i_rdata;
      F3_BU:   o_rdata_ext = {24'd0, w_byte};
      F3_HU:   o_rdata_ext = {16'd0, w_half};
      default: o_rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a single-cycle RV32 core and a req/ack data memory.
// Accepts a core load/store, registers it onto the memory port, holds the core
// in stall until the memory acks (or times out), then returns the extended
// load result for one cycle while the core advances.
// Ports:
//   CLK, RESET          : clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite   : core access request (both set = store)
//   funct3, daddr       : access size/sign and byte address
//   ddata_w / ddata_r   : store data in / extended load result out
//   stall               : core must hold PC and inputs
//   misaligned, bus_err : one-cycle error pulses
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata : registered memory request
//   mem_rdata, mem_ack  : memory response (ack is a one-cycle strobe)
// The lane logic assumes 32-bit data; address_size sets the bus widths.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int address_size = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              funct3,
  input  logic [address_size-1:0] daddr,
  input  logic [address_size-1:0] ddata_w,
  output logic [address_size-1:0] ddata_r,
  output logic                    stall,
  output logic                    misaligned,
  output logic                    bus_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [address_size-3:0] mem_addr,
  output logic [3:0]              mem_be,
  output logic [address_size-1:0] mem_wdata,
  input  logic [address_size-1:0] mem_rdata,
  input  logic                    mem_ack
);

  // Counter holds 0..TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e              r_state;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [address_size-3:0] r_mem_addr;
  logic [3:0]              r_mem_be;
  logic [address_size-1:0] r_mem_wdata;
  logic [2:0]              r_funct3;
  logic [1:0]              r_addr_lo;
  logic [address_size-1:0] r_rdata;
  logic [CW-1:0]           r_count;

  logic                    w_access;
  logic                    w_is_store;
  logic                    w_legal;
  logic                    w_misal;
  logic                    w_start;
  logic                    w_reject;
  logic [3:0]              w_be;
  logic [31:0]             w_wdata;
  logic [31:0]             w_rdata_ext;

  assign w_access   = MemRead | MemWrite;
  assign w_is_store = MemWrite;

  lsu_align u_align (
    .i_is_store    (w_is_store),
    .i_req_funct3  (funct3),
    .i_req_addr_lo (daddr[1:0]),
    .i_wdata       (ddata_w),
    .i_ld_funct3   (r_funct3),
    .i_ld_addr_lo  (r_addr_lo),
    .i_rdata       (r_rdata),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .o_legal       (w_legal),
    .o_misaligned  (w_misal),
    .o_rdata_ext   (w_rdata_ext)
  );

  // Requests are only looked at in IDLE; the core holds them stable otherwise.
  assign w_start  = (r_state == IDLE) && w_access && w_legal && !w_misal;
  assign w_reject = (r_state == IDLE) && w_access && !(w_legal && !w_misal);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= '0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_rdata     <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= daddr[address_size-1:2];
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_funct3    <= funct3;
            r_addr_lo   <= daddr[1:0];
            r_count     <= '0;
          end
        end
        REQ: begin
          // An ack in the final timeout cycle still completes the access.
          if (mem_ack) begin
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_state   <= DONE;
            r_mem_req <= 1'b0;
          end else if (r_count == COUNT_LAST) begin
            r_state   <= ERR;
            r_mem_req <= 1'b0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

  // The accept cycle stalls combinationally so the core does not advance
  // before the request is on the bus.
  assign stall      = (r_state == REQ) || w_start;
  assign misaligned = w_reject;
  assign bus_err    = (r_state == ERR);
  assign ddata_r    = ((r_state == DONE) && !r_mem_we) ? w_rdata_ext : '0;

endmodule
